// File: rtl/encoder_16x4_pkg.sv
// encoder_16x4 shared definitions: widths, FSM states, code mapping.
// Optional build macro: ENCODER_RR_ARB_EN (round-robin request selection).
package encoder_16x4_pkg;

    localparam int NUM_LINES = 16;
    localparam int CODE_W    = 4;

    typedef logic [NUM_LINES-1:0] line_vec_t;
    typedef logic [CODE_W-1:0]    code_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } enc_state_e;

    // index = 8*w + 4*x + 2*y + z, returned as {w, x, y, z}
    function automatic logic [3:0] idx_to_wxyz(input code_t idx);
        logic w_b;
        logic x_b;
        logic y_b;
        logic z_b;
        w_b = idx[3];
        x_b = idx[2];
        y_b = idx[1];
        z_b = idx[0];
        return {w_b, x_b, y_b, z_b};
    endfunction

    // one-hot mask selecting a single request line
    function automatic line_vec_t idx_to_onehot(input code_t idx);
        line_vec_t m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/encoder_16x4_priority_enc16.sv
// Combinational 16-to-4 search: first set bit at or after start, wrapping.
// start = 0 gives plain lowest-index-first priority.
module priority_enc16
    import encoder_16x4_pkg::*;
(
    input  line_vec_t pending,
    input  code_t     start,
    output code_t     index,
    output logic      found
);

    logic [2*NUM_LINES-1:0] dbl;
    line_vec_t              rot;
    code_t                  off;

    // rotate so the start position lands on bit 0, then pick lowest set bit
    always_comb begin
        dbl   = {pending, pending};
        rot   = line_vec_t'(dbl >> start);
        off   = '0;
        found = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = code_t'(i);
                found = 1'b1;
            end
        end
        index = found ? code_t'(off + start) : '0;
    end

endmodule

// File: rtl/encoder_16x4.sv
// encoder_16x4: captures active-low requests and serves them one code at a time.
// Optional build macro: ENCODER_RR_ARB_EN (round-robin selection with pointer).
module encoder_16x4
    import encoder_16x4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:15] D_n,
    input  logic        load,
    input  logic        ready,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic        w,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        empty
);

    enc_state_e state_q;
    enc_state_e state_d;
    line_vec_t  pend_q;
    line_vec_t  pend_d;
    line_vec_t  req;
    code_t      code_q;
    code_t      code_d;
    logic       valid_q;
    logic       valid_d;
    logic       done_q;
    logic       done_d;
    logic       empty_q;
    logic       empty_d;
    logic       take;
    code_t      start;
    code_t      sel_idx;
    logic       sel_found;

    assign take = valid_q & ready;

    // request lines in index order, active-high
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            req[i] = ~D_n[i];
        end
    end

    // next state and next pending set
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        empty_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    pend_d = req;
                    if (|req) begin
                        state_d = ST_BUSY;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (take) begin
                    pend_d = pend_q & ~idx_to_onehot(code_q);
                    if (pend_d == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ENCODER_RR_ARB_EN
    code_t ptr_q;
    code_t ptr_d;

    // pointer moves past each accepted index and survives across batches
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_BUSY && take) begin
            ptr_d = code_t'(code_q + 4'd1);
        end
        start = ptr_d;
    end

    // round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // fixed priority: always search from index 0
    always_comb begin
        start = '0;
    end
`endif

    priority_enc16 u_penc (
        .pending (pend_d),
        .start   (start),
        .index   (sel_idx),
        .found   (sel_found)
    );

    // next code is chosen from the next pending set so outputs stay registered
    always_comb begin
        valid_d = (state_d == ST_BUSY) && sel_found;
        code_d  = valid_d ? sel_idx : '0;
    end

    // state, pending set and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            empty_q <= empty_d;
        end
    end

    assign {w, x, y, z} = idx_to_wxyz(code_q);
    assign valid = valid_q;
    assign busy  = (state_q == ST_BUSY);
    assign done  = done_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_encoder_16x4.sv
// tb_encoder_16x4: scoreboard bench for encoder_16x4 with directed and random loads.
// Honours ENCODER_RR_ARB_EN for the expected serving order.
module tb_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:15] D_n = '1;
    logic        load = 1'b0;
    logic        ready = 1'b0;
    logic        x;
    logic        y;
    logic        z;
    logic        w;
    logic        valid;
    logic        busy;
    logic        done;
    logic        empty;

    int vectors = 0;
    int miscompares = 0;

    int exp_q[$];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_empty = 1'b0;
    int m_ptr = 0;

    encoder_16x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D_n   (D_n),
        .load  (load),
        .ready (ready),
        .x     (x),
        .y     (y),
        .z     (z),
        .w     (w),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected serving order of a freshly captured batch
    function automatic int build(input logic [0:15] dn);
        int start;
        int n;
        int i;
        n = 0;
`ifdef ENCODER_RR_ARB_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < 16; k++) begin
            i = (start + k) % 16;
            if (dn[i] == 1'b0) begin
                exp_q.push_back(i);
                n++;
            end
        end
        return n;
    endfunction

    // monitor: check this cycle against the model, then advance the model
    always @(negedge clk) begin
        logic [3:0] code;
        int         idx;
        int         n;
        bit         was_busy;
        code = {w, x, y, z};
        if (!rst_n) begin
            chk("reset_outputs", {27'd0, valid, busy, done, empty, |code}, 32'd0);
            exp_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_empty = 1'b0;
            m_ptr = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("valid", valid, m_busy);
            chk("done", done, m_done);
            chk("empty", empty, m_empty);
            if (m_busy) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard: code %0d with no expected entry", code);
                end else begin
                    chk("code", code, exp_q[0]);
                end
            end else begin
                chk("idle_code", code, 0);
            end
            m_done = 1'b0;
            m_empty = 1'b0;
            was_busy = m_busy;
            if (m_busy && ready && exp_q.size() > 0) begin
                idx = exp_q.pop_front();
                m_ptr = (idx + 1) % 16;
                if (exp_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (!was_busy && load) begin
                n = build(D_n);
                if (n == 0) m_empty = 1'b1;
                else m_busy = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [0:15] mk3(input int a, input int b, input int c);
        logic [0:15] v;
        v = '1;
        if (a >= 0) v[a] = 1'b0;
        if (b >= 0) v[b] = 1'b0;
        if (c >= 0) v[c] = 1'b0;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_reset", {24'd0, valid, busy, done, empty, w, x, y, z}, 32'd0);
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;

        // no active request -> empty pulse
        D_n = '1;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(3);

        // single request 13
        D_n = mk3(13, -1, -1);
        load = 1'b1;
        ready = 1'b1;
        step(1);
        load = 1'b0;
        step(3);

        // batch 2,5,9 with continuous ready
        D_n = mk3(2, 5, 9);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(5);

        // same batch, first code stalled 3 cycles, load ignored meanwhile
        load = 1'b1;
        ready = 1'b0;
        step(1);
        D_n = mk3(0, 15, -1);
        step(3);
        load = 1'b0;
        ready = 1'b1;
        step(5);

        // reset after code 5 accepted
        D_n = mk3(2, 5, 9);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        do_reset();
        step(3);
        D_n = mk3(7, -1, -1);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(4);

        // round-robin pair {3,10} then {3,12} from a fresh pointer
        do_reset();
        D_n = mk3(3, 10, -1);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        D_n = mk3(3, 12, -1);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(4);

        // random traffic
        for (int r = 0; r < 400; r++) begin
            load = ($urandom_range(0, 3) == 0);
            D_n = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            step(1);
        end

        // drain
        load = 1'b0;
        ready = 1'b1;
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
